// File: rtl/mc_control.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the Minisys-style MIPS core.
// Issues per-cycle datapath strobes, decodes memory-mapped I/O and counts retired instructions.
module mc_control #(
  parameter int ADDR_W     = 32,
  parameter int IO_SEL_LSB = 10,
  parameter logic [ADDR_W-IO_SEL_LSB-1:0] IO_BASE = 22'h3FFFFF,
  parameter int MEM_LAT    = 1,
  parameter int IO_TIMEOUT = 255,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic              zero,
  input  logic              io_ready,
  output logic [2:0]        state,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              io_read,
  output logic              io_write,
  output logic [1:0]        pc_src,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              sftmd,
  output logic              jal,
  output logic              memorio_to_reg,
  output logic [1:0]        alu_op,
  output logic              instr_done,
  output logic              illegal,
  output logic              io_timeout,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;

  // One counter serves both the memory latency and the I/O wait.
  localparam int CNT_MAX = (IO_TIMEOUT > 4) ? IO_TIMEOUT : 4;
  localparam int WAIT_W  = $clog2(CNT_MAX + 1);

  state_t            st;
  logic [5:0]        op_q, fn_q;
  logic              is_io;
  logic [WAIT_W-1:0] wait_cnt;

  // Live decode, used only while the instruction sits in ID.
  logic id_j, id_jal, id_legal;
  assign id_j     = (opcode == 6'b000010);
  assign id_jal   = (opcode == 6'b000011);
  assign id_legal = (opcode == 6'b000000) || id_j || id_jal ||
                    (opcode == 6'b000100) || (opcode == 6'b000101) ||
                    (opcode[5:3] == 3'b001) ||
                    (opcode == 6'b100011) || (opcode == 6'b101011);

  logic q_r, q_jr, q_beq, q_bne, q_i, q_lw, q_sw;
  assign q_r   = (op_q == 6'b000000);
  assign q_jr  = q_r && (fn_q == 6'b001000);
  assign q_beq = (op_q == 6'b000100);
  assign q_bne = (op_q == 6'b000101);
  assign q_i   = (op_q[5:3] == 3'b001);
  assign q_lw  = (op_q == 6'b100011);
  assign q_sw  = (op_q == 6'b101011);

  logic lat_last, tmo_hit, mem_done, addr_io;
  assign lat_last = (wait_cnt == WAIT_W'(MEM_LAT - 1));
  assign tmo_hit  = (wait_cnt == WAIT_W'(IO_TIMEOUT - 1));
  assign mem_done = is_io ? (io_ready || tmo_hit) : (q_sw || lat_last);
  assign addr_io  = (alu_result[ADDR_W-1:IO_SEL_LSB] == IO_BASE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_result[IO_SEL_LSB-1:0];

  logic       ir_write_c, pc_write_c, reg_write_c, mem_read_c, mem_write_c;
  logic       io_read_c, io_write_c, jal_c, m2r_c, illegal_c, io_timeout_c;
  logic [1:0] pc_src_c;
  logic       sel_valid;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    io_read_c    = 1'b0;
    io_write_c   = 1'b0;
    jal_c        = 1'b0;
    m2r_c        = 1'b0;
    illegal_c    = 1'b0;
    io_timeout_c = 1'b0;
    pc_src_c     = 2'd0;
    unique case (st)
      S_IF: ir_write_c = 1'b1;
      S_ID: begin
        if (!id_legal) begin
          illegal_c  = 1'b1;
          pc_write_c = 1'b1;
        end else if (id_j || id_jal) begin
          pc_write_c  = 1'b1;
          pc_src_c    = 2'd2;
          reg_write_c = id_jal;
          jal_c       = id_jal;
        end
      end
      S_EX: begin
        if (q_beq || q_bne) begin
          pc_write_c = 1'b1;
          pc_src_c   = (q_beq ? zero : !zero) ? 2'd1 : 2'd0;
        end else if (q_jr) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'd3;
        end
      end
      S_MEM: begin
        if (is_io) begin
          io_read_c    = q_lw;
          io_write_c   = q_sw;
          io_timeout_c = tmo_hit && !io_ready;
          pc_write_c   = q_sw && mem_done;
        end else begin
          mem_read_c  = q_lw;
          mem_write_c = q_sw;
          pc_write_c  = q_sw;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        m2r_c       = q_lw;
        pc_write_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel_valid = (st == S_EX) || (st == S_MEM) || (st == S_WB);

  // Strobes are forced low while reset is held, including ir_write in the reset IF state.
  assign state          = st;
  assign ir_write       = reset_n & ir_write_c;
  assign pc_write       = reset_n & pc_write_c;
  assign reg_write      = reset_n & reg_write_c;
  assign mem_read       = reset_n & mem_read_c;
  assign mem_write      = reset_n & mem_write_c;
  assign io_read        = reset_n & io_read_c;
  assign io_write       = reset_n & io_write_c;
  assign pc_src         = reset_n ? pc_src_c : 2'd0;
  assign jal            = reset_n & jal_c;
  assign memorio_to_reg = reset_n & m2r_c;
  assign illegal        = reset_n & illegal_c;
  assign io_timeout     = reset_n & io_timeout_c;
  assign instr_done     = reset_n & pc_write_c;
  assign reg_dst        = reset_n & sel_valid & q_r;
  assign alu_src        = reset_n & sel_valid & (q_i || q_lw || q_sw);
  assign sftmd          = reset_n & sel_valid & q_r &
                          (fn_q[5:3] == 3'b000) & (fn_q[2:0] != 3'b001) & (fn_q[2:0] != 3'b101);
  assign alu_op         = (reset_n && sel_valid) ? {q_r || q_i, q_beq || q_bne} : 2'b00;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IF;
      op_q        <= '0;
      fn_q        <= '0;
      is_io       <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      if (pc_write_c) instr_count <= instr_count + CNT_W'(1);
      unique case (st)
        S_IF: st <= S_ID;
        S_ID: begin
          op_q <= opcode;
          fn_q <= funct;
          st   <= (!id_legal || id_j || id_jal) ? S_IF : S_EX;
        end
        S_EX: begin
          is_io    <= addr_io;
          wait_cnt <= '0;
          if (q_beq || q_bne || q_jr) st <= S_IF;
          else if (q_lw || q_sw)      st <= S_MEM;
          else                        st <= S_WB;
        end
        S_MEM: begin
          if (mem_done) begin
            wait_cnt <= '0;
            st       <= q_lw ? S_WB : S_IF;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB:    st <= S_IF;
        default: st <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-instruction vector table plus
// hand-written reset sequences around an interrupted I/O load.
module tb_mc_control;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [31:0] alu_result = '0;
  logic        zero = 1'b0, io_ready = 1'b0;
  logic [2:0]  state;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write;
  logic [1:0]  pc_src, alu_op;
  logic        reg_dst, alu_src, sftmd, jal, memorio_to_reg;
  logic        instr_done, illegal, io_timeout;
  logic [3:0]  instr_count;

  mc_control #(.MEM_LAT(3), .IO_TIMEOUT(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .alu_result(alu_result), .zero(zero), .io_ready(io_ready), .state(state),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src), .sftmd(sftmd), .jal(jal),
    .memorio_to_reg(memorio_to_reg), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .io_timeout(io_timeout), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic [31:0] addr;
    logic        zero;
    int          ready_at;   // MEM cycle (1-based) from which io_ready is high; 0 = never
    int          cpi;
    logic [1:0]  pc_src;
    logic        rw, jl, ill;
    int          mrd, mwr, io;
    logic        tmo, m2r;
    logic [4:0]  sel;        // {reg_dst, alu_src, sftmd, alu_op} seen in EX
  } vec_t;

  function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic z, input int rdy, input int cpi,
                              input logic [1:0] pcs, input logic rw, input logic jl,
                              input logic il, input int mrd, input int mwr, input int io,
                              input logic tmo, input logic m2r, input logic [4:0] sel);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.addr = a; v.zero = z; v.ready_at = rdy;
    v.cpi = cpi; v.pc_src = pcs; v.rw = rw; v.jl = jl; v.ill = il;
    v.mrd = mrd; v.mwr = mwr; v.io = io; v.tmo = tmo; v.m2r = m2r; v.sel = sel;
    return v;
  endfunction

  function automatic logic [25:0] all_outs();
    return {state, ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write,
            pc_src, reg_dst, alu_src, sftmd, jal, memorio_to_reg, alu_op,
            instr_done, illegal, io_timeout, instr_count};
  endfunction

  // Runs one instruction from its IF cycle to the edge after retirement.
  task automatic run_instr(input vec_t v);
    int cyc = 0, mem_idx = 0, nmrd = 0, nmwr = 0, nio = 0, nir = 0;
    logic rw_s = 0, jl_s = 0, ill_s = 0, tmo_s = 0, m2r_s = 0, leak = 0, retired = 0, done_s = 0;
    logic [1:0] pcs = '0;
    logic [4:0] sel_s = '0;
    opcode = v.op; funct = v.fn; alu_result = v.addr; zero = v.zero; io_ready = 1'b0;
    for (int c = 0; c < 64 && !retired; c++) begin
      @(negedge clock);
      if (state == 3'd3) mem_idx++;
      io_ready = (state == 3'd3) && (v.ready_at != 0) && (mem_idx >= v.ready_at);
      #1;
      if (c == 0) begin
        check({v.name, " start_state"}, 32'(state), 32'd0);
        check({v.name, " start_count"}, 32'(instr_count), 32'(exp_count % 16));
      end
      cyc++;
      nir  += int'(ir_write);
      nmrd += int'(mem_read);
      nmwr += int'(mem_write);
      nio  += int'(io_read | io_write);
      rw_s  |= reg_write;
      jl_s  |= jal;
      ill_s |= illegal;
      tmo_s |= io_timeout;
      m2r_s |= memorio_to_reg;
      if (state == 3'd2) sel_s = {reg_dst, alu_src, sftmd, alu_op};
      if (state <= 3'd1 && {reg_dst, alu_src, sftmd, alu_op} != 5'b0) leak = 1'b1;
      if (pc_write) begin
        retired = 1'b1;
        pcs     = pc_src;
        done_s  = instr_done;
      end
    end
    @(posedge clock);
    #1;
    io_ready = 1'b0;
    exp_count++;
    check({v.name, " retired"},   32'(retired), 32'd1);
    check({v.name, " cpi"},       32'(cyc),     32'(v.cpi));
    check({v.name, " pc_src"},    32'(pcs),     32'(v.pc_src));
    check({v.name, " instr_done"},32'(done_s),  32'd1);
    check({v.name, " ir_write"},  32'(nir),     32'd1);
    check({v.name, " reg_write"}, 32'(rw_s),    32'(v.rw));
    check({v.name, " jal"},       32'(jl_s),    32'(v.jl));
    check({v.name, " illegal"},   32'(ill_s),   32'(v.ill));
    check({v.name, " mem_read"},  32'(nmrd),    32'(v.mrd));
    check({v.name, " mem_write"}, 32'(nmwr),    32'(v.mwr));
    check({v.name, " io_cycles"}, 32'(nio),     32'(v.io));
    check({v.name, " io_timeout"},32'(tmo_s),   32'(v.tmo));
    check({v.name, " m2r"},       32'(m2r_s),   32'(v.m2r));
    check({v.name, " selects"},   32'(sel_s),   32'(v.sel));
    check({v.name, " sel_leak"},  32'(leak),    32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    int mem_seen;
    vecs[0]  = mk("add",      6'h00, 6'h20, 32'h0,        1'b0, 0, 4,  2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b10010);
    vecs[1]  = mk("addi",     6'h08, 6'h00, 32'h0,        1'b0, 0, 4,  2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b01010);
    vecs[2]  = mk("j",        6'h02, 6'h00, 32'h0,        1'b0, 0, 2,  2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[3]  = mk("beq_t",    6'h04, 6'h00, 32'h0,        1'b1, 0, 3,  2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00001);
    vecs[4]  = mk("bne_nt",   6'h05, 6'h00, 32'h0,        1'b1, 0, 3,  2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00001);
    vecs[5]  = mk("lw_mem",   6'h23, 6'h00, 32'h00000010, 1'b0, 1, 7,  2'd0, 1'b1, 1'b0, 1'b0, 3, 0, 0, 1'b0, 1'b1, 5'b01000);
    vecs[6]  = mk("sw_io_k4", 6'h2B, 6'h00, 32'hFFFFFC60, 1'b0, 4, 7,  2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1'b0, 1'b0, 5'b01000);
    vecs[7]  = mk("lw_io_tmo",6'h23, 6'h00, 32'hFFFFFC70, 1'b0, 0, 12, 2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 8, 1'b1, 1'b1, 5'b01000);
    vecs[8]  = mk("sw_mem",   6'h2B, 6'h00, 32'h00000020, 1'b0, 0, 4,  2'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0, 5'b01000);
    vecs[9]  = mk("lw_io_k1", 6'h23, 6'h00, 32'hFFFFFC80, 1'b0, 1, 5,  2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b1, 5'b01000);
    vecs[10] = mk("sw_io_k8", 6'h2B, 6'h00, 32'hFFFFFC90, 1'b0, 8, 11, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 8, 1'b0, 1'b0, 5'b01000);
    vecs[11] = mk("sll",      6'h00, 6'h00, 32'h0,        1'b0, 0, 4,  2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b10110);
    vecs[12] = mk("j_a",      6'h02, 6'h00, 32'h0,        1'b0, 0, 2,  2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[13] = mk("j_b",      6'h02, 6'h00, 32'h0,        1'b0, 0, 2,  2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[14] = mk("j_c",      6'h02, 6'h00, 32'h0,        1'b0, 0, 2,  2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[15] = mk("illegal",  6'h3F, 6'h00, 32'h0,        1'b0, 0, 2,  2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[16] = mk("jal",      6'h03, 6'h00, 32'h0,        1'b0, 0, 2,  2'd2, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b00000);
    vecs[17] = mk("jr",       6'h00, 6'h08, 32'h0,        1'b0, 0, 3,  2'd3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 5'b10010);

    // Power-on reset: everything quiet, then release just after an edge.
    repeat (3) @(negedge clock);
    #1;
    check("por all_outputs_zero", 32'(all_outs()), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_instr(vecs[2]);

    // Start an I/O load and reset it in its third MEM cycle.
    opcode = 6'h23; funct = 6'h00; alu_result = 32'hFFFFFC70; zero = 1'b0; io_ready = 1'b0;
    mem_seen = 0;
    for (int c = 0; c < 20 && mem_seen < 3; c++) begin
      @(negedge clock);
      #1;
      if (state == 3'd3) mem_seen++;
    end
    check("pre_reset reached_mem", 32'(mem_seen), 32'd3);
    check("pre_reset io_read", 32'(io_read), 32'd1);
    check("pre_reset count", 32'(instr_count), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_mem_reset all_outputs_zero", 32'(all_outs()), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    check("held_reset all_outputs_zero", 32'(all_outs()), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_count = 0;

    // Main table; its first entry also checks the post-release IF cycle.
    for (int i = 0; i < 18; i++) run_instr(vecs[i]);

    @(negedge clock);
    #1;
    check("final wrapped count", 32'(instr_count), 32'(exp_count % 16));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the Minisys-style MIPS core. It replaces the single-cycle combinational decoder with a five-state sequencer (IF/ID/EX/MEM/WB) that issues per-cycle strobes. It also provides:
- parametrised memory-mapped I/O decode;
- a configurable memory read latency;
- an `io_ready` handshake with timeout;
- a retired-instruction counter.

It sits between the instruction register/ALU and the PC, register file, data memory and I/O bus.

## Interface
Parameters:
- `ADDR_W`, 32: ALU result / address width.
- `IO_SEL_LSB`, 10: lowest address bit compared for I/O select.
- `IO_BASE`, 22'h3FFFFF: value of `alu_result[ADDR_W-1:IO_SEL_LSB]` that selects I/O. Width is `ADDR_W-IO_SEL_LSB`.
- `MEM_LAT`, 1: data-memory read latency in cycles. Legal range 1..4.
- `IO_TIMEOUT`, 255: maximum MEM cycles spent waiting for `io_ready`. Legal range ≥1.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clock`, in, 1: sole clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 6: instruction[31:26], live from the IR.
- `funct`, in, 6: instruction[5:0], live from the IR.
- `alu_result`, in, `ADDR_W`: ALU output, valid in EX.
- `zero`, in, 1: ALU zero flag, valid in EX.
- `io_ready`, in, 1: I/O device completion strobe.
- `state`, out, 3: current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- `ir_write`, `pc_write`, `reg_write`, `mem_read`, `mem_write`, `io_read`, `io_write`, out, 1 each: per-cycle strobes.
- `pc_src`, out, 2: next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- `reg_dst`, `alu_src`, `sftmd`, `jal`, `memorio_to_reg`, out, 1 each: datapath selects.
- `alu_op`, out, 2: {R or I-format, beq or bne}.
- `instr_done`, `illegal`, `io_timeout`, out, 1 each: one-cycle event pulses.
- `instr_count`, out, `CNT_W`: count of retired instructions.

## Operation
Instruction classes:
- R: opcode 000000. It is `jr` when `funct` = 001000.
- j: 000010. jal: 000011.
- beq: 000100. bne: 000101.
- I-format: 001xxx.
- lw: 100011. sw: 101011.
- Any other opcode is illegal.

Decode latching and static selects:
- `opcode` and `funct` are latched into decode registers on the ID→next edge.
- `reg_dst`, `alu_src`, `alu_op` and `sftmd` come from the latched values.
  - Encoding matches the single-cycle decoder: `sftmd` for R-type with `funct` ∈ {00,02,03,04,06,07}.
  - These selects are valid in EX, MEM and WB; outside those states they are 0.
- I/O select is computed from live `alu_result` on the EX→MEM edge and latched as `is_io`.

Per-state behaviour (strobes are combinational decode of state and latched registers):
- IF: `ir_write`=1 → ID.
- ID, j: `pc_write`=1, `pc_src`=2 → IF.
- ID, jal: `pc_write`=1, `pc_src`=2, `reg_write`=1, `jal`=1 → IF.
- ID, illegal opcode: `illegal`=1, `pc_write`=1, `pc_src`=0 → IF. No register or memory side effects.
- ID, all other classes: → EX.
- EX, beq/bne: `pc_write`=1, `pc_src` = 1 if taken (beq: `zero`; bne: !`zero`), else 0 → IF.
- EX, jr: `pc_write`=1, `pc_src`=3 → IF.
- EX, R or I-format: → WB.
- EX, lw or sw: → MEM.
- MEM, sw to memory: `mem_write`=1 for one cycle, `pc_write`=1, `pc_src`=0 → IF.
- MEM, lw from memory: `mem_read`=1 for exactly `MEM_LAT` cycles, then → WB.
- MEM, I/O access: `io_read` (lw) or `io_write` (sw) is held high until `io_ready` is sampled high.
  - Exit on `io_ready`: lw → WB; sw → IF with `pc_write`=1.
  - A wait counter counts MEM cycles. If `io_ready` is still low in the `IO_TIMEOUT`-th cycle, `io_timeout` pulses in that cycle and the block exits exactly as if ready.
- WB: `reg_write`=1, `memorio_to_reg`=1 for lw only, `pc_write`=1, `pc_src`=0 → IF.

Retirement:
- `instr_done` pulses in the cycle `pc_write`=1, including for illegal instructions.
- `instr_count` increments on that edge and wraps modulo 2^`CNT_W`.
- `io_ready` is ignored except in MEM with `is_io`=1.

## Timing
Cycles per instruction:
- j/jal/illegal: 2.
- beq/bne/jr: 3.
- R, I-format, sw to memory: 4.
- lw from memory: 4+`MEM_LAT`.
- I/O access: 3+k for sw, 4+k for lw, where k ∈ [1,`IO_TIMEOUT`] is the number of MEM cycles.

Boundary conditions:
- `io_ready` high in the first MEM cycle gives k=1.
- `io_ready` and timeout in the same cycle: treated as ready, `io_timeout`=0.

Reset:
- While `reset_n` is low, every output is 0 and `state`=IF.
- On assertion, `instr_count`, the decode registers, `is_io` and the wait/latency counters clear immediately, even mid-instruction.
- The first cycle after release is IF with `ir_write`=1.

## Test plan
- Reset mid-MEM of an I/O lw, then release → all outputs 0 during reset; `state`=0, `ir_write`=1 on the first cycle after release; `instr_count`=0.
- Sequence add(R), addi(001000), j, beq with `zero`=1, bne with `zero`=1 → CPIs 4,4,2,3,3. beq `pc_src`=1; bne `pc_src`=0. `instr_count`=5.
- lw with `alu_result`=0x00000010, `MEM_LAT`=3 → `mem_read` high 3 cycles, WB `memorio_to_reg`=1, CPI 7.
- sw with `alu_result`=0xFFFFFC60, `io_ready` raised in the 4th MEM cycle → `io_write` high 4 cycles, then `pc_write`, CPI 7, `io_timeout`=0.
- lw to 0xFFFFFC70 with `io_ready` stuck low, `IO_TIMEOUT`=8 → 8 MEM cycles, `io_timeout` pulse in the 8th, WB follows.
- opcode 111111, then jal, then jr ($31) → `illegal` pulse (CPI 2); jal `reg_write`+`jal`+`pc_src`=2; jr `pc_src`=3 with `reg_write`=0. Set `instr_count` to 2^`CNT_W`−1 beforehand → it wraps to 0.
